// File: rtl/gbuff_pkg.sv
// Shared types and constants for the global buffer and its burst read path.
package gbuff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } gbuff_state_e;

    // Output FIFO depth; also the credit limit for outstanding reads.
    localparam int GBUFF_FIFO_DEPTH = 4;
    localparam int GBUFF_CNT_BITS   = $clog2(GBUFF_FIFO_DEPTH + 1);

    // LSB position of bank b inside a packed row.
    function automatic int gbuff_slice_lsb(input int b, input int data_bits);
        return b * data_bits;
    endfunction

endpackage

// File: rtl/gbuff_stream_fifo.sv
// Shift-register FIFO: the head entry is a flop, so the consumer sees
// registered data that holds while it is stalled.
module gbuff_stream_fifo
    import gbuff_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic [GBUFF_CNT_BITS-1:0] count
);

    localparam int IDX_BITS = $clog2(GBUFF_FIFO_DEPTH);

    logic [WIDTH-1:0]    entries [GBUFF_FIFO_DEPTH];
    logic                do_pop;
    logic                do_push;
    logic [IDX_BITS-1:0] wr_idx;

    // Qualify push/pop against occupancy; a push into a full FIFO only lands alongside a pop.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != GBUFF_CNT_BITS'(GBUFF_FIFO_DEPTH)) || do_pop);
        wr_idx  = count[IDX_BITS-1:0] - IDX_BITS'(do_pop);
    end

    // Storage shifts toward the head on pop; the new entry goes behind the last valid one.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < GBUFF_FIFO_DEPTH; i++) begin
                entries[i] <= '0;
            end
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < GBUFF_FIFO_DEPTH - 1; i++) begin
                    entries[i] <= entries[i+1];
                end
                entries[GBUFF_FIFO_DEPTH-1] <= '0;
            end
            if (do_push) begin
                entries[wr_idx] <= push_data;
            end
            if (do_push && !do_pop) begin
                count <= count + GBUFF_CNT_BITS'(1);
            end else if (do_pop && !do_push) begin
                count <= count - GBUFF_CNT_BITS'(1);
            end
        end
    end

    assign head_data = entries[0];

endmodule

// File: rtl/global_buffer_burst.sv
// Banked global buffer: masked row writes plus a strided burst reader that
// streams rows out over valid/ready through a small credit-managed FIFO.
//
// state | meaning
// IDLE  | waiting for a burst command, cmd_ready high
// ISSUE | issuing one row read per cycle while FIFO credit allows
// DRAIN | all reads issued, waiting for the last beat to be popped
module global_buffer_burst
    import gbuff_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int BANKS     = 4,
    localparam int DEPTH    = 2 ** ADDR_BITS,
    localparam int ROW_BITS = BANKS * DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BANKS-1:0]     wr_mask,
    input  logic [ROW_BITS-1:0]  wr_data,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_base,
    input  logic [ADDR_BITS-1:0] cmd_stride,
    input  logic [ADDR_BITS-1:0] cmd_len,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ROW_BITS-1:0]  rd_data,
    output logic                 rd_last,
    output logic                 busy
);

    gbuff_state_e state_q, state_d;

    logic [ADDR_BITS-1:0]      addr_acc;
    logic [ADDR_BITS-1:0]      stride_q;
    logic [ADDR_BITS-1:0]      beats_left;
    logic                      cmd_fire;
    logic                      issue;
    logic                      issue_last;
    logic                      credit_ok;
    logic                      s1_valid;
    logic                      s1_last;
    logic [1:0]                pending;
    logic [ROW_BITS-1:0]       bank_row;
    logic [ROW_BITS:0]         fifo_head;
    logic [GBUFF_CNT_BITS-1:0] fifo_count;
    logic                      pop_fire;

    // Reads in flight sit in the bank output register for one cycle before the push.
    assign pending    = {1'b0, s1_valid};
    assign credit_ok  = ({1'b0, fifo_count} + 4'(pending)) < 4'(GBUFF_FIFO_DEPTH);
    assign cmd_fire   = (state_q == IDLE) && cmd_valid;
    assign issue_last = (beats_left == '0);
    assign pop_fire   = rd_valid && rd_ready;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and issue decision.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop_fire && rd_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address accumulator and remaining-beat down-counter; len is beats minus one,
    // so the read issued at terminal count zero is the last one.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_acc   <= '0;
            stride_q   <= '0;
            beats_left <= '0;
        end else if (cmd_fire) begin
            addr_acc   <= cmd_base;
            stride_q   <= cmd_stride;
            beats_left <= cmd_len;
        end else if (issue) begin
            addr_acc <= addr_acc + stride_q;
            if (!issue_last) begin
                beats_left <= beats_left - ADDR_BITS'(1);
            end
        end
    end

    // Tracks which bank output register holds a read waiting to be pushed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_last  <= issue && issue_last;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        localparam int LSB = gbuff_slice_lsb(b, DATA_BITS);

        logic [DATA_BITS-1:0] gbuff [DEPTH];
        logic [DATA_BITS-1:0] rd_q;

        // Read-first dual-port bank; contents survive reset.
        always_ff @(posedge clk_i) begin
            if (wr_en && wr_mask[b]) begin
                gbuff[wr_addr] <= wr_data[LSB +: DATA_BITS];
            end
            if (issue) begin
                rd_q <= gbuff[addr_acc];
            end
        end

        assign bank_row[LSB +: DATA_BITS] = rd_q;
    end

    gbuff_stream_fifo #(
        .WIDTH (ROW_BITS + 1)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (s1_valid),
        .push_data ({s1_last, bank_row}),
        .pop       (pop_fire),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign rd_valid  = (fifo_count != '0);
    assign rd_data   = fifo_head[ROW_BITS-1:0];
    assign rd_last   = fifo_head[ROW_BITS];
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_global_buffer_burst.sv
// Scoreboard bench for global_buffer_burst: a row-level reference memory
// produces expected beats when each burst command is driven.
module tb_global_buffer_burst;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NB = 4;
    localparam int RB = NB * DB;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [NB-1:0] wr_mask;
    logic [RB-1:0] wr_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AB-1:0] cmd_base;
    logic [AB-1:0] cmd_stride;
    logic [AB-1:0] cmd_len;
    logic          rd_valid;
    logic          rd_ready;
    logic [RB-1:0] rd_data;
    logic          rd_last;
    logic          busy;

    global_buffer_burst #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .BANKS     (NB)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_base   (cmd_base),
        .cmd_stride (cmd_stride),
        .cmd_len    (cmd_len),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .busy       (busy)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic [RB-1:0] model [2**AB];
    logic [RB:0]   exp_q [$];
    int            pop_cyc [$];
    bit            rec_lat = 1'b0;
    bit            cnt_mon = 1'b0;
    int            acc_cyc;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Output monitor: pops the scoreboard on each accepted beat and checks hold-while-stalled.
    logic [RB:0] held;
    bit          held_v = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (held_v && rd_valid) check("hold_stable", {rd_last, rd_data}, held);
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) check("spurious_beat", 1, 0);
                else check("beat", {rd_last, rd_data}, exp_q.pop_front());
                if (rec_lat) pop_cyc.push_back(cyc);
            end
            if (cnt_mon) check("fifo_count_le4", (dut.fifo_count <= 4), 1);
            held_v = rd_valid && !rd_ready;
            held   = {rd_last, rd_data};
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_row(input logic [AB-1:0] a, input logic [RB-1:0] d, input logic [NB-1:0] m);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
        tick();
        wr_en   = 1'b0;
        wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            if (m[b]) model[a][b*DB +: DB] = d[b*DB +: DB];
        end
    endtask

    task automatic start_burst(input logic [AB-1:0] base, input logic [AB-1:0] stride, input int len);
        logic [AB-1:0] a;
        int guard = 0;
        while (!cmd_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        cmd_valid  = 1'b1;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_len    = AB'(len);
        acc_cyc    = cyc;
        a = base;
        for (int k = 0; k <= len; k++) begin
            exp_q.push_back({(k == len), model[a]});
            a = a + stride;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // mode 0: rd_ready held high; mode 1: rd_ready pattern 1,0,0,1,0,0,...
    task automatic run_until_idle(input int mode);
        int i = 0;
        while ((busy || exp_q.size() != 0) && i < 1000) begin
            rd_ready = (mode == 0) ? 1'b1 : ((i % 3) == 0);
            tick();
            i++;
        end
        if (i >= 1000) check("drain_timeout", 0, 1);
        rd_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_len = '0; rd_ready = 1'b0;
        for (int r = 0; r < 2**AB; r++) model[r] = '0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rd_valid",  rd_valid,  0);
        check("rst_rd_last",   rd_last,   0);
        check("rst_rd_data",   rd_data,   0);
        check("rst_busy",      busy,      0);
        rst_i = 1'b1;
        tick();

        // Sequential rows, full rate, latency and cmd_ready return.
        for (int r = 0; r < 4; r++) write_row(AB'(r), 32'h03020100 + 32'h04040404 * r, 4'hF);
        rd_ready = 1'b1;
        rec_lat  = 1'b1;
        start_burst(8'd0, 8'd1, 3);
        run_until_idle(0);
        rec_lat = 1'b0;
        check("lat_count", pop_cyc.size(), 4);
        for (int i = 0; i < 4 && i < pop_cyc.size(); i++) check("lat_beat", pop_cyc[i], acc_cyc + 3 + i);
        check("cmd_ready_rise_cyc", cyc, acc_cyc + 7);
        check("cmd_ready_back", cmd_ready, 1);

        // Masked write.
        write_row(8'd5, 32'hAAAAAAAA, 4'hF);
        write_row(8'd5, 32'h11223344, 4'b0101);
        start_burst(8'd5, 8'd0, 0);
        run_until_idle(0);

        // Wrap and stride: rows 254, 1, 4.
        write_row(8'd254, 32'hDEADBEEF, 4'hF);
        write_row(8'd4,   32'h13579BDF, 4'hF);
        start_burst(8'd254, 8'd3, 2);
        run_until_idle(0);

        // Stride 0 repeats one row.
        start_burst(8'd3, 8'd0, 2);
        run_until_idle(0);

        // Backpressure over 8 beats.
        write_row(8'd6, 32'hCAFEF00D, 4'hF);
        write_row(8'd7, 32'h0BADC0DE, 4'hF);
        cnt_mon = 1'b1;
        start_burst(8'd0, 8'd1, 7);
        run_until_idle(1);
        cnt_mon = 1'b0;

        // Collision: write row 2 in the cycle its read issues.
        start_burst(8'd2, 8'd1, 0);
        write_row(8'd2, 32'h00000055, 4'hF);
        run_until_idle(0);
        start_burst(8'd2, 8'd1, 0);
        run_until_idle(0);

        // Reset while draining.
        rd_ready = 1'b0;
        start_burst(8'd0, 8'd1, 2);
        repeat (5) tick();
        check("pre_rst_valid", rd_valid, 1);
        check("pre_rst_busy",  busy,     1);
        rst_i = 1'b0;
        #1;
        check("mid_rst_valid",     rd_valid,  0);
        check("mid_rst_busy",      busy,      0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        exp_q.delete();
        tick();
        rst_i = 1'b1;
        tick();
        check("post_rst_valid", rd_valid,  0);
        check("post_rst_data",  rd_data,   0);
        check("post_rst_ready", cmd_ready, 1);
        rd_ready = 1'b1;
        start_burst(8'd0, 8'd1, 2);
        run_until_idle(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/global_buffer_burst.md
# global_buffer_burst

Banked, parametrised global buffer for the TPU datapath. BANKS parallel banks share one row address, so each row holds BANKS × DATA_BITS bits. A masked row-write port is always accepted. A command-driven burst reader streams strided rows to the systolic array through a valid/ready interface with full backpressure. Bank contents are not reset.

## Interface
Parameters:
- ADDR_BITS, 8, row address width; DEPTH = 2**ADDR_BITS rows
- DATA_BITS, 8, word width per bank
- BANKS, 4, number of banks (≥1); row width ROW_BITS = BANKS*DATA_BITS

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- wr_en  in  1  row write strobe, always accepted
- wr_addr  in  ADDR_BITS  write row
- wr_mask  in  BANKS  per-bank write enable; bit b gates bank b
- wr_data  in  ROW_BITS  bank b occupies bits [b*DATA_BITS +: DATA_BITS]
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  high only in IDLE
- cmd_base  in  ADDR_BITS  first row
- cmd_stride  in  ADDR_BITS  row increment per beat
- cmd_len  in  ADDR_BITS  beats minus one (1..DEPTH beats)
- rd_valid  out  1  beat available
- rd_ready  in  1  consumer accepts beat
- rd_data  out  ROW_BITS  beat data
- rd_last  out  1  final beat of burst
- busy  out  1  burst in progress (not IDLE)

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE on cmd_valid & cmd_ready. Capture base, stride, len. Beat counter = 0.
- ISSUE: one read issued per cycle when credit allows. Beat k reads row (base + k*stride) mod DEPTH. Address is an accumulator wrapping at DEPTH; stride 0 repeats one row.
- ISSUE → DRAIN in the cycle the read with k == len is issued.
- DRAIN → IDLE on pop of the last beat (rd_valid & rd_ready & rd_last).
- Credit: issue only if fifo_count + pending < 4. pending counts reads issued but not yet pushed (0..2). No beat is ever dropped or duplicated.
- rd_last is carried through the FIFO with the data. It is set only on beat k == len.
- Write/read collision on the same row in the same cycle: read returns old data (read-first), and the write completes. wr_en is independent of FSM state.
- cmd_valid is ignored outside IDLE. No abort.
- Reset mid-burst:
  - FSM → IDLE; FIFO, pending and counters are cleared.
  - Bank contents are preserved; a write in flight at assertion is not guaranteed.
- Reset values: cmd_ready = 1, rd_valid = 0, rd_last = 0, rd_data = 0, busy = 0.

## Timing
- Writes: data is visible to a read issued in the cycle after the wr_en cycle.
- Read latency: cmd accepted in cycle T → first read issued T+1 → bank output T+2 → pushed into FIFO at end of T+2 → rd_valid first high in cycle T+3.
- With rd_ready held high, one beat is delivered per cycle, with no bubbles, from T+3 to T+3+len.
- Backpressure: while rd_valid & !rd_ready, rd_data and rd_last hold stable. Issue stalls once credit is exhausted, and resumes the cycle after a pop frees credit.
- cmd_ready rises in the cycle after the last-beat pop. The earliest next acceptance is that cycle.

## Structure
- Package gbuff_pkg holds:
  - the state enum gbuff_state_e {IDLE, ISSUE, DRAIN}
  - constant GBUFF_FIFO_DEPTH = 4
  - the row-slice helper function for bank b
- Banks: BANKS instances of a simple dual-port, read-first array, written with a generate loop; the array is named gbuff per bank.
- Sub-module gbuff_stream_fifo:
  - synchronous FIFO, depth GBUFF_FIFO_DEPTH, width ROW_BITS+1
  - exposes count, registered outputs, asynchronous active-low reset

## Test plan
- Writes: write rows 0..3 with data 0x03020100 + 0x04040404*row and wr_mask 4'hF. Then burst base 0, stride 1, len 3, with rd_ready held high → beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in cycles T+3..T+6; rd_last only on the 4th beat.
- Masked write: row 5 holds 0xAAAAAAAA; write 0x11223344 with mask 4'b0101 → burst len 0 from row 5 returns 0xAA22AA44.
- Wrap and stride: base 254, stride 3, len 2 (ADDR_BITS = 8) → rows 254, 1, 4 are read in order.
- Backpressure: 8-beat burst with rd_ready toggling 1,0,0,1,… → all 8 beats arrive in order with none lost or duplicated; data is stable while stalled; fifo_count never exceeds 4.
- Collision: wr_en to row 2 with new data 0x55 in the same cycle the burst reads row 2 → the old value is returned, and a subsequent burst returns 0x55.
- Reset mid-burst: assert rst_i low during DRAIN → next cycle rd_valid = 0, busy = 0, cmd_ready = 1; a re-read after reset returns the pre-reset contents.
